imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width (legal values 32, 64).
REQ-002 SHALL have parameter TAG_W, default 8, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, the upstream instruction is valid.
REQ-007 SHALL have port in_ready, output, 1, the block can accept an instruction this cycle.
REQ-008 SHALL have port instruction, input, 32, full instruction word.
REQ-009 SHALL have port immgen_en_d, input, 1, enable from the Control Unit; when low, the entry carries imm 0 and type NONE.
REQ-010 SHALL have port in_tag, input, TAG_W, sideband tag passed through unchanged.
REQ-011 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the head entry.
REQ-013 SHALL have port imm_out, output, XLEN, sign- or zero-extended immediate of the head entry.
REQ-014 SHALL have port imm_type, output, 3, format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the head entry.

Function
REQ-016 SHALL decode on opcode[6:0]:
  - I-type (0010011, 0000011, 1100111): {inst[31:20]} sign-extended.
  - S-type (0100011): {inst[31:25], inst[11:7]} sign-extended.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0} sign-extended from bit 31 to XLEN.
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - Any other opcode: imm 0, type NONE.
REQ-017 SHALL hold decoded results in a 2-entry in-order FIFO with a 2-bit occupancy counter (0..2).
REQ-018 SHALL accept (push) when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < 2), driven from registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); the head entry SHALL be visible in the cycle after the push edge (latency 1).
REQ-021 Simultaneous push and pop at count 1 SHALL leave count 1 and preserve order.
REQ-022 At count 2, in_ready SHALL be 0; a pop in that cycle SHALL raise in_ready on the next cycle.
REQ-023 Head outputs SHALL stay stable while out_valid && !out_ready.
REQ-024 flush SHALL set count to 0 on the next edge, dropping any same-cycle push and pop; in_ready SHALL be 1 afterwards.
REQ-025 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-026 When rst is high at a clock edge, count, rd_ptr and wr_ptr SHALL be 0; rst SHALL take precedence over flush, push and pop.
REQ-027 After reset: out_valid=0, in_ready=1, imm_out=0, imm_type=0, out_tag=0; reset mid-stream SHALL discard all entries.

Configuration
REQ-028 Macro IMMGEN_ZIMM_EN SHALL control CSR zimm decoding.
  - Defined: opcode 1110011 with funct3[2]=1 SHALL yield imm = zero-extended inst[19:15] and type Z.
  - Undefined: opcode 1110011 SHALL yield imm 0 and type NONE.

Verification
REQ-029 XLEN=32: push 0xFFF00093 -> next cycle imm_out=0xFFFFFFFF, imm_type=1; push 0x00112623 -> imm_out=0x0000000C, imm_type=2.
REQ-030 Push 0xFE000EE3 -> imm_out=0xFFFFFFFC, type 3; push 0x123450B7 -> imm_out=0x12345000, type 4; with XLEN=64, push 0x800000B7 -> imm_out=0xFFFFFFFF80000000.
REQ-031 Push 0x3002D073 -> with IMMGEN_ZIMM_EN: imm_out=5, type 6; without it: imm_out=0, type 0. Push 0xFFF00093 with immgen_en_d=0 -> imm_out=0, type 0.
REQ-032 Backpressure:
  - Hold out_ready=0 and offer tags 1, 2, 3 back-to-back -> in_ready=0 after two accepts, tag 3 stalled.
  - Then raise out_ready -> out_tag sequence 1, 2, 3, with no loss or duplication.
REQ-033 Fill to count 2, then assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle instruction never appears.
REQ-034 Assert rst while count=2 -> next cycle out_valid=0, in_ready=1 and all outputs 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder into a 2-entry in-order FIFO; IMMGEN_ZIMM_EN adds CSR zimm decode.
// Head visible 1 cycle after push; in_ready = count < 2 from registered state, stalls when full.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic             immgen_en_d,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_type,
   output logic [TAG_W-1:0] out_tag
);
   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_I    = 3'd1;
   localparam logic [2:0] T_S    = 3'd2;
   localparam logic [2:0] T_B    = 3'd3;
   localparam logic [2:0] T_U    = 3'd4;
   localparam logic [2:0] T_J    = 3'd5;
`ifdef IMMGEN_ZIMM_EN
   localparam logic [2:0] T_Z    = 3'd6;
`endif

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       kind;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t            mem [2];
   entry_t            dec_dat;
   entry_t            head;
   logic [1:0]        count;
   logic              rd_ptr;
   logic              wr_ptr;
   logic              push;
   logic              pop;
   logic [31:0]       imm32;
   logic [2:0]        dec_type;
   logic [XLEN-1:0]   imm_ext;

   always_comb begin
      imm32    = '0;
      dec_type = T_NONE;
      if (immgen_en_d) begin
         case (instruction[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
               imm32    = {{20{instruction[31]}}, instruction[31:20]};
               dec_type = T_I;
            end
            7'b0100011: begin
               imm32    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
               dec_type = T_S;
            end
            7'b1100011: begin
               imm32    = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
               dec_type = T_B;
            end
            7'b0110111, 7'b0010111: begin
               imm32    = {instruction[31:12], 12'b0};
               dec_type = T_U;
            end
            7'b1101111: begin
               imm32    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
               dec_type = T_J;
            end
`ifdef IMMGEN_ZIMM_EN
            7'b1110011: begin
               // Only the CSR*I forms (funct3[2]=1) carry a 5-bit unsigned zimm in rs1.
               if (instruction[14]) begin
                  imm32    = {27'b0, instruction[19:15]};
                  dec_type = T_Z;
               end
            end
`endif
            default: begin
               imm32    = '0;
               dec_type = T_NONE;
            end
         endcase
      end
   end

   // imm32[31] is zero for zimm, so a uniform sign extension covers every format.
   always_comb begin
      imm_ext       = {XLEN{imm32[31]}};
      imm_ext[31:0] = imm32;
   end

   assign dec_dat = '{imm: imm_ext, kind: dec_type, tag: in_tag};

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage needs no reset: head outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dec_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head     = mem[rd_ptr];
   assign imm_out  = out_valid ? head.imm  : '0;
   assign imm_type = out_valid ? head.kind : T_NONE;
   assign out_tag  = out_valid ? head.tag  : '0;

endmodule
